// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared definitions for the memory-port arbiter.
//   - arb_state_e : one-hot arbiter FSM encodings (IDLE/ISSUE/WAIT/RESP)
//   - PORT_FETCH  : requester index of the instruction-fetch port
//   - PORT_DATA   : requester index of the execute/store data port
package mem_arbiter_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_RESP  = 4'b1000
    } arb_state_e;

    localparam int PORT_FETCH = 0;
    localparam int PORT_DATA  = 1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: 2-input round-robin select, purely combinational.
//   req_i [1:0] : per-port request
//   ptr_i       : priority pointer, names the preferred port on contention
//   gnt_o [1:0] : one-hot winner (all zero when nobody requests)
module rr_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        unique case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_i ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (port 0)
// and data access (port 1). Round-robin, one transaction in flight, with a
// watchdog that completes a hung access with an error.
//   clk, reset (async, active low)
//   I_req/I_we/I_addr*/I_wdata* : per-port request and payload
//   O_gnt   : one-cycle accept pulse (payload may drop after it)
//   O_done  : one-cycle completion pulse, O_err qualifies it (timeout)
//   O_rdata : shared read data, valid with O_done on reads
//   I_mem_ready/O_mem_execute/O_mem_*/I_mem_data_ready/I_mem_rdata :
//             memory-side command/response handshake
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter int          DATA_W  = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        I_req,
    input  logic [1:0]        I_we,
    input  logic [ADDR_W-1:0] I_addr0,
    input  logic [ADDR_W-1:0] I_addr1,
    input  logic [DATA_W-1:0] I_wdata0,
    input  logic [DATA_W-1:0] I_wdata1,
    output logic [1:0]        O_gnt,
    output logic [1:0]        O_done,
    output logic              O_err,
    output logic [DATA_W-1:0] O_rdata,
    input  logic              I_mem_ready,
    output logic              O_mem_execute,
    output logic              O_mem_we,
    output logic [ADDR_W-1:0] O_mem_addr,
    output logic [DATA_W-1:0] O_mem_wdata,
    input  logic              I_mem_data_ready,
    input  logic [DATA_W-1:0] I_mem_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              win_q, win_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [1:0]        pick;
    logic [1:0]        gnt_c;
    logic [CNT_W:0]    cnt_nxt;
    logic              to_hit;

    rr_pick u_pick (
        .req_i (I_req),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // cnt_nxt counts WAIT cycles including the current one, so the access
    // times out after exactly TIMEOUT cycles spent in WAIT.
    assign cnt_nxt = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign to_hit  = (TIMEOUT != 0) && (cnt_nxt == (CNT_W + 1)'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        rdata_d     = rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt_c       = 2'b00;

        unique case (state_q)
            S_IDLE: begin
                if (I_mem_ready && (I_req != 2'b00)) begin
                    gnt_c   = pick;
                    win_d   = pick[PORT_DATA];
                    err_d   = 1'b0;
                    state_d = S_ISSUE;
                    if (pick[PORT_DATA]) begin
                        mem_we_d    = I_we[PORT_DATA];
                        mem_addr_d  = I_addr1;
                        mem_wdata_d = I_wdata1;
                    end else begin
                        mem_we_d    = I_we[PORT_FETCH];
                        mem_addr_d  = I_addr0;
                        mem_wdata_d = I_wdata0;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_nxt[CNT_W-1:0];
                // data_ready is checked first so it beats a same-cycle timeout
                if (I_mem_data_ready) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    if (!mem_we_q) begin
                        rdata_d = I_mem_rdata;
                    end
                end else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ptr_d   = ~ptr_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            win_q       <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Grant is decided combinationally in IDLE; masking with reset keeps it
    // low while reset is held even if requests are present.
    assign O_gnt         = gnt_c & {2{reset}};
    assign O_mem_execute = (state_q == S_ISSUE);
    assign O_done        = (state_q == S_RESP) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign O_err         = (state_q == S_RESP) && err_q;
    assign O_rdata       = rdata_q;
    assign O_mem_we      = mem_we_q;
    assign O_mem_addr    = mem_addr_q;
    assign O_mem_wdata   = mem_wdata_q;

endmodule
